// File: rtl/cpu_mem_arbiter.sv
// Two-master (instruction/data) arbiter onto one shared memory port with a
// single outstanding transaction; data has priority with bounded starvation.
module cpu_mem_arbiter #(
  parameter int unsigned DATA_BURST_MAX = 2
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] BURST_MAX = 4'(DATA_BURST_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  state_t      state, state_nxt;
  owner_t      owner, owner_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        wr_q, wr_nxt;
  logic [3:0]  wstrb_q, wstrb_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] wdata_q, wdata_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      owner   <= OWN_INST;
      cnt     <= '0;
      wr_q    <= 1'b0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      cnt     <= cnt_nxt;
      wr_q    <= wr_nxt;
      wstrb_q <= wstrb_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    cnt_nxt      = cnt;
    wr_nxt       = wr_q;
    wstrb_nxt    = wstrb_q;
    addr_nxt     = addr_q;
    wdata_nxt    = wdata_q;

    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_wstrb    = '0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state)
      IDLE: begin
        // Grants are combinational, so gate them while reset holds outputs low.
        if (rst) begin
          if (data_req && !(inst_req && (cnt == BURST_MAX))) begin
            data_addr_ok = 1'b1;
            owner_nxt    = OWN_DATA;
            wr_nxt       = data_wr;
            wstrb_nxt    = data_wr ? data_wstrb : 4'b0000;
            addr_nxt     = data_addr;
            wdata_nxt    = data_wdata;
            state_nxt    = REQ;
            if (inst_req)
              cnt_nxt = (cnt >= BURST_MAX) ? BURST_MAX : cnt + 4'd1;
            else
              cnt_nxt = '0;
          end else if (inst_req) begin
            inst_addr_ok = 1'b1;
            owner_nxt    = OWN_INST;
            wr_nxt       = 1'b0;
            wstrb_nxt    = '0;
            addr_nxt     = inst_addr;
            wdata_nxt    = '0;
            state_nxt    = REQ;
            cnt_nxt      = '0;
          end
        end
      end

      REQ: begin
        mem_req   = 1'b1;
        mem_wr    = wr_q;
        mem_wstrb = wstrb_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_addr_ok)
          state_nxt = RESP;
      end

      RESP: begin
        if (mem_data_ok) begin
          if (owner == OWN_DATA) begin
            data_data_ok = 1'b1;
            data_rdata   = mem_rdata;
          end else begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem_rdata;
          end
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
